// File: rtl/led_seq_pkg.sv
// led_seq_pkg: pattern encodings, FSM states and LED pattern step functions
package led_seq_pkg;
    typedef enum logic [2:0] {
        M_WALK_L = 3'd0,
        M_WALK_R = 3'd1,
        M_PING   = 3'd2,
        M_BLINK  = 3'd3,
        M_COUNT  = 3'd4,
        M_FILL   = 3'd5
    } mode_t;

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_HOLD} state_t;

    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;

    typedef struct packed {
        logic [7:0] led;
        dir_t       dir;
    } pat_t;

    // Unused encodings 6 and 7 fall back to walk-left.
    function automatic mode_t norm_mode(input logic [2:0] m);
        return (m > 3'd5) ? M_WALK_L : mode_t'(m);
    endfunction

    function automatic logic [7:0] init_pattern(input logic [2:0] m);
        case (norm_mode(m))
            M_WALK_R: return 8'h80;
            M_BLINK:  return 8'hFF;
            M_COUNT:  return 8'h00;
            default:  return 8'h01;
        endcase
    endfunction

    function automatic pat_t next_pattern(input logic [2:0] m, input logic [7:0] led, input dir_t dir);
        pat_t p;
        p.led = led;
        p.dir = dir;
        case (norm_mode(m))
            M_WALK_R: p.led = {led[0], led[7:1]};
            M_PING: begin
                p.led = (dir == DIR_LEFT) ? led << 1 : led >> 1;
                p.dir = (p.led == 8'h80) ? DIR_RIGHT : (p.led == 8'h01) ? DIR_LEFT : dir;
            end
            M_BLINK:  p.led = ~led;
            M_COUNT:  p.led = led + 8'd1;
            M_FILL:   p.led = (led == 8'hFF) ? 8'h00 : {led[6:0], 1'b1};
            default:  p.led = {led[6:0], led[7]};
        endcase
        return p;
    endfunction
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler producing a one-cycle step enable every TICK_DIV>>speed cycles
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned CNT_W    = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       run,
    input  logic [1:0] speed,
    output logic       tick
);
    localparam logic [CNT_W-1:0] DIV = CNT_W'(TICK_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lim;

    // >= so that a live speed increase past the current count fires at once
    always_comb begin
        lim  = (DIV >> speed) - CNT_W'(1);
        tick = run && (cnt >= lim);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else if (run)
            cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: LED bank pattern sequencer with run/hold/single-step and live mode/speed control
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned CNT_W    = 25
) (
    input  logic       CLK_50MHz,
    input  logic       Reset_n,
    input  logic       enable,
    input  logic [2:0] mode,
    input  logic [1:0] speed,
    input  logic       step,
    output logic [7:0] LED,
    output logic       step_tick,
    output logic       running
);
    state_t     state, state_nxt;
    dir_t       dir;
    logic [2:0] mode_q;
    logic       mode_chg, adv, clear, tick;
    pat_t       nxt;

    led_tick_gen #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_tick (
        .clk   (CLK_50MHz),
        .rst_n (Reset_n),
        .clear (clear),
        .run   (running),
        .speed (speed),
        .tick  (tick)
    );

    // A pending mode change swallows any tick or step in the same cycle.
    always_comb begin
        mode_chg  = (state != S_LOAD) && (mode != mode_q);
        running   = state == S_RUN;
        adv       = !mode_chg && ((running && enable && tick) || (state == S_HOLD && step));
        clear     = !running || !enable || mode_chg;
        nxt       = next_pattern(mode_q, LED, dir);
        state_nxt = (state == S_LOAD) ? (enable ? S_RUN : S_HOLD) :
                    mode_chg          ? S_LOAD :
                    enable            ? S_RUN  : S_HOLD;
    end

    always_ff @(posedge CLK_50MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_LOAD;
            LED       <= 8'h00;
            dir       <= DIR_LEFT;
            mode_q    <= 3'd0;
            step_tick <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_tick <= adv;
            if (state == S_LOAD) begin
                LED    <= init_pattern(mode);
                dir    <= DIR_LEFT;
                mode_q <= mode;
            end else if (adv) begin
                LED <= nxt.led;
                dir <= nxt.dir;
            end
        end
    end
endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Pattern sequencer and rate controller for the 8-bit board LED bank. Runs entirely in the 50 MHz domain: an internal prescaler produces step enables (no derived clocks), and an FSM selects and advances one of six display patterns. Supports run, freeze, single-step and live mode/speed changes. Sits between the board switches/debounced buttons and the LED pins.

## Interface
- TICK_DIV, default 25_000_000 — clock cycles per step at speed 0 (0.5 s at 50 MHz); benches use 8
- CNT_W, default 25 — prescaler width; must satisfy 2^CNT_W > TICK_DIV
- CLK_50MHz  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = RUN (auto-advance), 0 = HOLD (frozen)
- mode  in  3  pattern select: 0 walk-left, 1 walk-right, 2 ping-pong, 3 blink, 4 binary count, 5 fill bar; 6–7 behave as 0
- speed  in  2  step period = TICK_DIV >> speed cycles
- step  in  1  synchronous 1-cycle pulse, already debounced; advances one pattern in HOLD only
- LED  out  8  display pattern
- step_tick  out  1  registered 1-cycle pulse in the cycle after every pattern advance
- running  out  1  high in S_RUN

## Operation
- FSM states: S_LOAD, S_RUN, S_HOLD.
- Reset: state = S_LOAD; LED = 8'h00; step_tick = 0; running = 0; prescaler = 0; dir = left; mode_q = 0.
- S_LOAD (exactly one cycle): LED <= init(mode); mode_q <= mode; prescaler <= 0; dir <= left; next = enable ? S_RUN : S_HOLD.
- init values: walk-left 8'h01, walk-right 8'h80, ping-pong 8'h01, blink 8'hFF, count 8'h00, fill 8'h01.
- Advance rules:
  - walk-left: rotate left, 80→01.
  - walk-right: rotate right, 01→80.
  - ping-pong: one-hot shifts in dir; reaching 80 flips dir to right, reaching 01 flips to left. Period 14 steps, no repeated end value.
  - blink: bitwise invert.
  - count: +1 mod 256; FF→00.
  - fill: {LED[6:0],1'b1}; FF→00; 00→01.
- S_RUN: prescaler increments each cycle. When prescaler >= period−1, prescaler <= 0 and LED advances. enable=0 → S_HOLD with prescaler cleared and LED kept.
- S_HOLD: LED frozen. A step pulse advances once. enable=1 → S_RUN with prescaler starting from 0.
- Mode change (mode != mode_q) in S_RUN or S_HOLD → S_LOAD next cycle. Any tick or step in the same cycle is dropped; mode change has priority.
- step in S_RUN or S_LOAD is ignored.
- speed is combinational into the period compare and takes effect immediately. If the period shrinks below the current count, the >= compare advances on that edge.

## Timing
- Each advance updates LED on the same edge that clears the prescaler. step_tick is high the following cycle.
- RUN step spacing: exactly TICK_DIV>>speed cycles between LED changes.
- First advance after S_LOAD→S_RUN or S_HOLD→S_RUN: period cycles after entry.
- Step in HOLD: LED changes on the edge sampling step. step_tick follows one cycle later.
- Mode change latency: mode sampled at edge N → S_LOAD at N+1 → LED = init at edge N+2.
- Reset assertion mid-operation clears all outputs asynchronously. After release, the first edge executes S_LOAD.

## Structure
- Package led_seq_pkg:
  - mode encodings
  - state enum {S_LOAD, S_RUN, S_HOLD}
  - init_pattern(mode) function
  - next_pattern(mode, led, dir) function returning led and dir
- Sub-module led_tick_gen:
  - contains the prescaler
  - inputs: clear, run, speed
  - output: combinational tick
  - parameters: TICK_DIV, CNT_W
- Top level holds the FSM, the LED/dir registers, mode_q and the step_tick register.

## Test plan
- Reset then run, TICK_DIV=8, mode 0, speed 0, enable=1 → LED 00, then 01 one cycle after release, then 02, 04 … 80, 01 every 8 cycles; step_tick pulses each time.
- Ping-pong, speed 2 (period 2) → LED 01,02,…,80,40,…,02,01,02 changing every 2 cycles; 80 and 01 each appear once per turn.
- HOLD with step: enable=0, mode 4, three step pulses spaced 5 cycles apart → LED 00→01→02→03; no change between pulses. Same pulses with enable=1 → no effect from step.
- Mode change colliding with a tick: switch mode 0→5 on the cycle where the prescaler hits 7 → no advance; S_LOAD follows; LED = 01 two edges later; next change to 03 after 8 cycles.
- Speed shrink: in RUN with count=6, set speed 2 → advance on the next edge, then every 2 cycles. Mode 6 → behaves as walk-left (init 01).
- Reset mid-pattern: assert Reset_n low with LED=8'h1F in fill mode → LED=00, running=0 and step_tick=0 immediately; after release LED = init(mode).
